// File: rtl/wb_mem_readback_pkg.sv
// Shared types and constants for the Wishbone SRAM readback slave.
// Holds FSM state codes, register offsets, the ID word and the window bit.
package wb_readback_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ISSUE = 2'd1;
    localparam state_t ST_WAIT  = 2'd2;
    localparam state_t ST_ACK   = 2'd3;

    localparam logic [1:0] REG_STATUS    = 2'd0;
    localparam logic [1:0] REG_RD_COUNT  = 2'd1;
    localparam logic [1:0] REG_LAST_ADDR = 2'd2;
    localparam logic [1:0] REG_ID        = 2'd3;

    localparam logic [31:0] READBACK_ID = 32'h5242_0001;

    localparam int WIN_BIT = 11;

endpackage

// File: rtl/wb_mem_readback_if.sv
// Wishbone classic slave-side bundle for the readback block.
// The slave modport is used by the design, master by the bus driver.
interface wb_mem_readback_if;
    import wb_readback_pkg::*;

    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_adr_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i,
        input  wbs_sel_i, wbs_dat_i, wbs_adr_i,
        output wbs_ack_o, wbs_dat_o
    );

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i,
        output wbs_sel_i, wbs_dat_i, wbs_adr_i,
        input  wbs_ack_o, wbs_dat_o
    );

endinterface

// File: rtl/wb_mem_readback.sv
// Wishbone slave: word reads of SRAM port 1 plus a status/counter register set.
// Optional WB_READBACK_LA_EN adds la_data_out = {LAST_ADDR, last read data}.
module wb_mem_readback
    import wb_readback_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_1000,
    parameter int          AW         = 8,
    parameter int          RD_LATENCY = 1
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    wb_mem_readback_if.slave wbs,
    output logic            mem_csb1,
    output logic [AW-1:0]   mem_addr1,
    input  logic [31:0]     mem_dout1
`ifdef WB_READBACK_LA_EN
    ,
    output logic [63:0]     la_data_out
`endif
);

    state_t        r_state;
    logic [1:0]    r_cnt;
    logic          r_ack;
    logic [31:0]   r_dat;
    logic          r_csb;
    logic [AW-1:0] r_addr;
    logic [31:0]   r_rd_count;
    logic [AW-1:0] r_last;
    logic          r_err;

    logic          w_req;
    logic          w_hit;
    logic          w_sram;
    logic          w_mapped;
    logic [1:0]    w_off;
    logic [AW-1:0] w_word;
    logic          w_busy;
    logic          w_rd_done;
    logic          w_wr;
    logic          w_err_set;
    logic          w_err_clr;
    logic [31:0]   w_reg_rd;
    logic [31:0]   w_last32;
    logic          w_unused;

    assign w_req    = wbs.wbs_cyc_i & wbs.wbs_stb_i;
    assign w_hit    = w_req & (wbs.wbs_adr_i[31:12] == BASE_ADDR[31:12]);
    assign w_sram   = ~wbs.wbs_adr_i[WIN_BIT];
    assign w_mapped = (wbs.wbs_adr_i[10:4] == 7'd0);
    assign w_off    = wbs.wbs_adr_i[3:2];
    assign w_word   = wbs.wbs_adr_i[AW+1:2];
    assign w_busy   = (r_state != ST_IDLE);
    assign w_last32 = {{(32-AW){1'b0}}, r_last};

    assign w_rd_done = (r_state == ST_WAIT) & w_req & (r_cnt == 2'd0);

    // Sticky error: writes that hit read-only space; a clear always wins.
    assign w_wr      = (r_state == ST_IDLE) & w_hit & wbs.wbs_we_i;
    assign w_err_set = w_wr & (w_sram | (w_mapped & (w_off != REG_STATUS)));
    assign w_err_clr = w_wr & ~w_sram & w_mapped & (w_off == REG_STATUS)
                     & wbs.wbs_sel_i[0] & wbs.wbs_dat_i[1];

    always_comb begin
        w_reg_rd = 32'd0;
        if (w_mapped) begin
            unique case (1'b1)
                (w_off == REG_STATUS):    w_reg_rd = {30'd0, r_err, w_busy};
                (w_off == REG_RD_COUNT):  w_reg_rd = r_rd_count;
                (w_off == REG_LAST_ADDR): w_reg_rd = w_last32;
                (w_off == REG_ID):        w_reg_rd = READBACK_ID;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 2'd0;
            r_ack      <= 1'b0;
            r_dat      <= 32'd0;
            r_csb      <= 1'b1;
            r_addr     <= '0;
            r_rd_count <= 32'd0;
            r_last     <= '0;
        end else begin
            r_ack <= 1'b0;
            r_csb <= 1'b1;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_hit) begin
                        if (w_sram && !wbs.wbs_we_i) begin
                            r_state <= ST_ISSUE;
                            r_csb   <= 1'b0;
                            r_addr  <= w_word;
                        end else begin
                            r_state <= ST_ACK;
                            r_ack   <= 1'b1;
                            r_dat   <= wbs.wbs_we_i ? 32'd0 : w_reg_rd;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (!w_req) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_state <= ST_WAIT;
                        r_cnt   <= 2'(RD_LATENCY - 1);
                    end
                end
                ST_WAIT: begin
                    if (!w_req) begin
                        r_state <= ST_IDLE;
                    end else if (w_rd_done) begin
                        r_state    <= ST_ACK;
                        r_ack      <= 1'b1;
                        r_dat      <= mem_dout1;
                        r_rd_count <= r_rd_count + 32'd1;
                        r_last     <= r_addr;
                    end else begin
                        r_cnt <= r_cnt - 2'd1;
                    end
                end
                ST_ACK: begin
                    r_state <= ST_IDLE;
                    r_dat   <= 32'd0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_err <= 1'b0;
        end else if (w_err_clr) begin
            r_err <= 1'b0;
        end else if (w_err_set) begin
            r_err <= 1'b1;
        end
    end

`ifdef WB_READBACK_LA_EN
    logic [63:0] r_la;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_la <= 64'd0;
        end else if (w_rd_done) begin
            r_la <= {{(32-AW){1'b0}}, r_addr, mem_dout1};
        end
    end

    assign la_data_out = r_la;
`endif

    assign wbs.wbs_ack_o = r_ack;
    assign wbs.wbs_dat_o = r_dat;
    assign mem_csb1      = r_csb;
    assign mem_addr1     = r_addr;

    assign w_unused = ^{wbs.wbs_adr_i[1:0], wbs.wbs_sel_i[3:1],
                        wbs.wbs_dat_i[31:2], wbs.wbs_dat_i[0]};

endmodule
